// File: rtl/complex_mem_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | complex_mem_sequencer: read two complex operands, apply one saturated      |
// | ADD/SUB/MUL/CONJ, and write the result back to the complex-number memory.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module complex_mem_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [4:0] cmd_src_a,
  input  logic [4:0] cmd_src_b,
  input  logic [4:0] cmd_dst,
  output logic       mem_write,
  output logic [4:0] mem_addr_a,
  output logic [4:0] mem_addr_b,
  output logic [9:0] mem_data_a,
  output logic [9:0] mem_data_b,
  input  logic [9:0] mem_q_a,
  input  logic [9:0] mem_q_b,
  output logic       done,
  output logic [9:0] result,
  output logic       sat
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;

  logic [1:0] state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [4:0] src_a_q, src_a_d;
  logic [4:0] src_b_q, src_b_d;
  logic [4:0] dst_q, dst_d;
  logic [9:0] result_q, result_d;
  logic       sat_q, sat_d;
  logic       done_q, done_d;

  logic signed [10:0] a_re, a_im, b_re, b_im;
  logic signed [10:0] re_raw, im_raw;
  logic [5:0]         re_sat, im_sat;

  // Clamp to 5-bit two's complement; MSB of the return value flags saturation.
  function automatic logic [5:0] clamp5(input logic signed [10:0] v);
    if (v > 11'sd15)
      return {1'b1, 5'b01111};
    else if (v < -11'sd16)
      return {1'b1, 5'b10000};
    else
      return {1'b0, v[4:0]};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= 2'd0;
      src_a_q  <= 5'd0;
      src_b_q  <= 5'd0;
      dst_q    <= 5'd0;
      result_q <= 10'd0;
      sat_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      src_a_q  <= src_a_d;
      src_b_q  <= src_b_d;
      dst_q    <= dst_d;
      result_q <= result_d;
      sat_q    <= sat_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    a_re = {{6{mem_q_a[9]}}, mem_q_a[9:5]};
    a_im = {{6{mem_q_a[4]}}, mem_q_a[4:0]};
    b_re = {{6{mem_q_b[9]}}, mem_q_b[9:5]};
    b_im = {{6{mem_q_b[4]}}, mem_q_b[4:0]};
    case (op_q)
      OP_ADD: begin
        re_raw = a_re + b_re;
        im_raw = a_im + b_im;
      end
      OP_SUB: begin
        re_raw = a_re - b_re;
        im_raw = a_im - b_im;
      end
      OP_MUL: begin
        re_raw = a_re * b_re - a_im * b_im;
        im_raw = a_re * b_im + a_im * b_re;
      end
      default: begin
        re_raw = a_re;
        im_raw = -a_im;
      end
    endcase
    re_sat = clamp5(re_raw);
    im_sat = clamp5(im_raw);
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    src_a_d  = src_a_q;
    src_b_d  = src_b_q;
    dst_d    = dst_q;
    result_d = result_q;
    sat_d    = sat_q;
    done_d   = (state_q == S_WRITE);
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_READ;
          op_d    = cmd_op;
          src_a_d = cmd_src_a;
          src_b_d = cmd_src_b;
          dst_d   = cmd_dst;
        end
      end
      S_READ:  state_d = S_EXEC;
      S_EXEC: begin
        state_d  = S_WRITE;
        result_d = {re_sat[4:0], im_sat[4:0]};
        sat_d    = re_sat[5] | im_sat[5];
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode from state_q so an asynchronous reset drops mem_write at once.
  always_comb begin
    cmd_ready  = (state_q == S_IDLE);
    mem_write  = 1'b0;
    mem_addr_a = 5'd0;
    mem_addr_b = 5'd0;
    mem_data_a = 10'd0;
    mem_data_b = 10'd0;
    case (state_q)
      S_READ: begin
        mem_addr_a = src_a_q;
        mem_addr_b = src_b_q;
      end
      S_WRITE: begin
        mem_write  = 1'b1;
        mem_addr_a = dst_q;
        mem_addr_b = dst_q;
        mem_data_a = result_q;
        mem_data_b = result_q;
      end
      default: ;
    endcase
    done   = done_q;
    result = result_q;
    sat    = sat_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_complex_mem_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_complex_mem_sequencer: directed and random commands against a memory    |
// | model and an integer-arithmetic reference.  Revision: 1.0                  |
// +----------------------------------------------------------------------------+
module tb_complex_mem_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [4:0] cmd_src_a = 5'd0, cmd_src_b = 5'd0, cmd_dst = 5'd0;
  logic       mem_write;
  logic [4:0] mem_addr_a, mem_addr_b;
  logic [9:0] mem_data_a, mem_data_b;
  logic [9:0] mem_q_a, mem_q_b;
  logic       done;
  logic [9:0] result;
  logic       sat;

  logic [9:0] mem [0:31];
  logic [9:0] ref_mem [0:31];
  logic       pl_en = 1'b0;
  logic [4:0] pl_addr = 5'd0;
  logic [9:0] pl_data = 10'd0;

  int compared = 0;
  int mismatched = 0;
  int wr_count = 0;
  int done_count = 0;

  complex_mem_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
    .mem_write(mem_write), .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
    .mem_data_a(mem_data_a), .mem_data_b(mem_data_b),
    .mem_q_a(mem_q_a), .mem_q_b(mem_q_b),
    .done(done), .result(result), .sat(sat)
  );

  always #5 clk = ~clk;

  // Synchronous dual-port memory: read data appears the cycle after the address.
  always @(posedge clk) begin
    mem_q_a <= mem[mem_addr_a];
    mem_q_b <= mem[mem_addr_b];
    if (mem_write) begin
      mem[mem_addr_a] <= mem_data_a;
      mem[mem_addr_b] <= mem_data_b;
    end
    if (pl_en) mem[pl_addr] <= pl_data;
  end

  always @(posedge clk) begin
    if (mem_write) wr_count <= wr_count + 1;
    if (done) done_count <= done_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {sat, re[4:0], im[4:0]} from plain integer complex arithmetic.
  function automatic logic [10:0] ref_op(input logic [1:0] op, input logic [9:0] a, input logic [9:0] b);
    int ar, ai, br, bi, re, im;
    logic s;
    ar = $signed(a[9:5]); ai = $signed(a[4:0]);
    br = $signed(b[9:5]); bi = $signed(b[4:0]);
    case (op)
      2'b00:   begin re = ar + br; im = ai + bi; end
      2'b01:   begin re = ar - br; im = ai - bi; end
      2'b10:   begin re = ar * br - ai * bi; im = ar * bi + ai * br; end
      default: begin re = ar; im = -ai; end
    endcase
    s = 1'b0;
    if (re > 15) begin re = 15; s = 1'b1; end
    else if (re < -16) begin re = -16; s = 1'b1; end
    if (im > 15) begin im = 15; s = 1'b1; end
    else if (im < -16) begin im = -16; s = 1'b1; end
    return {s, re[4:0], im[4:0]};
  endfunction

  task automatic preload(input logic [4:0] a, input logic [9:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issue one command; returns with the bench positioned one step after the edge
  // where done is first seen, so a following call lands its accept on E4.
  task automatic run_cmd(input logic [1:0] op, input logic [4:0] sa, input logic [4:0] sb,
                         input logic [4:0] d, input logic [9:0] exp_res, input logic exp_sat,
                         input bit hold);
    int wr0, lat;
    wr0 = wr_count;
    lat = 0;
    cmd_op = op; cmd_src_a = sa; cmd_src_b = sb; cmd_dst = d; cmd_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_op = 2'($urandom_range(0, 3)); cmd_dst = 5'($urandom_range(0, 31));
    end
    check("ready_low_read", 32'(cmd_ready), 32'd0);
    check("done_low_read", 32'(done), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k < 3) check("ready_low_busy", 32'(cmd_ready), 32'd0);
      if (k == 2) begin
        check("write_en", 32'(mem_write), 32'd1);
        check("write_addr", {22'd0, mem_addr_a, mem_addr_b}, {22'd0, d, d});
        check("write_data", {12'd0, mem_data_a, mem_data_b}, {12'd0, exp_res, exp_res});
      end
      if (done) begin lat = k; break; end
    end
    check("done_latency", 32'(lat), 32'd3);
    check("ready_after", 32'(cmd_ready), 32'd1);
    check("result", 32'(result), 32'(exp_res));
    check("sat", 32'(sat), 32'(exp_sat));
    check("mem_dst", 32'(mem[d]), 32'(exp_res));
    check("write_count", 32'(wr_count - wr0), 32'd1);
  endtask

  initial begin
    int wr0, dn0;
    logic [10:0] r;
    logic [1:0]  op;
    logic [4:0]  sa, sb, d;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_outputs", {20'd0, mem_write, done, sat, mem_addr_a, mem_addr_b},  32'd0);
    check("rst_data", {12'd0, mem_data_a, mem_data_b}, 32'd0);
    check("rst_result", 32'(result), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed scenarios
    preload(5'd1, 10'h062);
    preload(5'd2, 10'h03F);
    run_cmd(2'b00, 5'd1, 5'd2, 5'd3, 10'h081, 1'b0, 0);
    run_cmd(2'b10, 5'd1, 5'd2, 5'd4, 10'h0BF, 1'b0, 0);
    preload(5'd5, 10'h1E0);
    preload(5'd6, 10'h020);
    preload(5'd9, 10'h200);
    preload(5'd11, 10'h010);
    run_cmd(2'b00, 5'd5, 5'd6, 5'd7, 10'h1E0, 1'b1, 0);
    run_cmd(2'b01, 5'd9, 5'd6, 5'd10, 10'h200, 1'b1, 0);
    run_cmd(2'b11, 5'd11, 5'd3, 5'd12, 10'h00F, 1'b1, 0);

    // Held cmd_valid: in-place CONJ twice, back to back, then nothing more
    run_cmd(2'b11, 5'd1, 5'd0, 5'd1, 10'h07E, 1'b0, 1);
    run_cmd(2'b11, 5'd1, 5'd0, 5'd1, 10'h062, 1'b0, 1);
    cmd_valid = 1'b0;
    wr0 = wr_count;
    repeat (6) @(posedge clk);
    #1;
    check("no_extra_exec", 32'(wr_count - wr0), 32'd0);

    // Back-to-back with distinct commands (second accepted while done is high)
    run_cmd(2'b01, 5'd1, 5'd2, 5'd13, 10'h043, 1'b0, 0);
    run_cmd(2'b00, 5'd13, 5'd13, 5'd14, 10'h086, 1'b0, 0);

    // Reset during EXEC of a command to dst 8
    preload(5'd8, 10'h155);
    wr0 = wr_count; dn0 = done_count;
    cmd_op = 2'b00; cmd_src_a = 5'd1; cmd_src_b = 5'd2; cmd_dst = 5'd8; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("abort_outputs", {20'd0, mem_write, done, sat, mem_addr_a, mem_addr_b}, 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    check("abort_result", 32'(result), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_mem8", 32'(mem[8]), 32'h155);
    check("abort_no_write", 32'(wr_count - wr0), 32'd0);
    check("abort_no_done", 32'(done_count - dn0), 32'd0);

    // Random commands against the reference model
    for (int i = 0; i < 32; i++) begin
      ref_mem[i] = 10'($urandom);
      preload(5'(i), ref_mem[i]);
    end
    for (int n = 0; n < 24; n++) begin
      op = 2'($urandom_range(0, 3));
      sa = 5'($urandom_range(0, 31));
      sb = (n % 4 == 0) ? sa : 5'($urandom_range(0, 31));
      d  = (n % 5 == 0) ? sa : 5'($urandom_range(0, 31));
      r  = ref_op(op, ref_mem[sa], ref_mem[sb]);
      ref_mem[d] = r[9:0];
      run_cmd(op, sa, sb, d, r[9:0], r[10], 0);
    end
    for (int i = 0; i < 32; i++) check("final_mem", 32'(mem[i]), 32'(ref_mem[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
